fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
- Initiator and controller for the FC parameter provider.
- Per layer, it requests the descriptor, then per neuron issues weight-fetch beats and drives activation read addresses and MAC lane controls.
- It waits for the MAC accumulation result, writes it to the output buffer, and advances to the next neuron and next layer until a layer flagged last completes.
- Sits between the top-level control, the FC parameter provider, the activation ping-pong buffers and the MAC datapath.

Parameters:
- INPUTS_MAC, 6: MAC lanes; weights per get_weight beat; activation address stride.
- ADDR_W, 16: width of activation and output addresses.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle pulse; begins network evaluation.
- busy out 1: high from the cycle after an accepted start until done.
- done out 1: one-cycle pulse when the last layer completes.
- next_layer out 1: pulse to provider requesting the next descriptor.
- next_neuron out 1: pulse to provider advancing to the next neuron's weights and bias.
- get_weight out 1: pulse to provider; kernel and bias are valid on the next cycle.
- struct_ready in 1: provider pulse; descriptor fields are valid in that cycle.
- cant_inputs in 16: inputs per neuron.
- iters_per_neuron in 16: get_weight beats per neuron.
- modulo in 8: valid lanes in the final beat; 0 means all lanes valid.
- cant_neurons in 8: neurons in the layer.
- last in 8: nonzero marks the final layer.
- of_offset in 16: output buffer base address.
- n in 8: requantization field, latched and forwarded.
- frac in 8: requantization field, latched and forwarded.
- act_rd_addr out ADDR_W: activation read address, presented in the get_weight cycle.
- act_bank out 1: activation bank to read; the output is written to the other bank.
- mac_en out 1: kernel, bias and activation valid this cycle.
- mac_clear out 1: with mac_en on the first beat of a neuron.
- mac_last out 1: with mac_en on the final beat of a neuron.
- mac_lane_mask out INPUTS_MAC: per-lane enable, valid with mac_en.
- acc_valid in 1: MAC result ready for the current neuron.
- out_wr_en out 1: one-cycle write strobe.
- out_wr_addr out ADDR_W: of_offset + neuron index.
- quant_n out 8: latched n.
- quant_frac out 8: latched frac.
- layer_idx out 8: index of the current layer.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- rst mid-operation aborts to IDLE in the next cycle with no further pulses. The provider shares the same rst.
- States: IDLE, REQ_LAYER, WAIT_DESC, FETCH, WAIT_ACC, NEXT_GAP, LAYER_END.
- IDLE:
  - start=1 leads to REQ_LAYER, with busy=1, layer_idx=0 and act_bank=0.
  - start while busy is ignored.
- REQ_LAYER: next_layer=1 for exactly one cycle, then WAIT_DESC.
- WAIT_DESC:
  - On struct_ready, latch all descriptor fields, set neuron_idx=0 and beat=0.
  - If cant_neurons==0 or iters_per_neuron==0, go to LAYER_END; otherwise go to FETCH.
  - Waits indefinitely for struct_ready.
- FETCH:
  - Each cycle: get_weight=1 and act_rd_addr=beat*INPUTS_MAC; beat increments.
  - After the beat == iters-1 cycle, go to WAIT_ACC.
- MAC controls are registered one cycle after get_weight:
  - mac_en=1.
  - mac_clear=1 when beat==0.
  - mac_last=1 when beat==iters-1.
  - mac_lane_mask is all ones, except on the final beat with modulo!=0, where it is (1<<modulo)-1.
  - modulo > INPUTS_MAC is treated as INPUTS_MAC.
- WAIT_ACC:
  - Held until acc_valid. An acc_valid that coincides with mac_last is accepted.
  - In the acceptance cycle: out_wr_en=1, out_wr_addr=of_offset+neuron_idx (mod 2^ADDR_W), next_neuron=1, neuron_idx increments, beat=0. Then go to NEXT_GAP.
  - acc_valid outside WAIT_ACC is ignored.
- NEXT_GAP:
  - One idle cycle so the provider can rebase its pointers; no get_weight is issued.
  - If neuron_idx==cant_neurons, go to LAYER_END; otherwise go to FETCH.
- LAYER_END:
  - If last!=0: done=1 and busy=0 in the same cycle, then IDLE. act_bank is held.
  - Otherwise: act_bank toggles, layer_idx increments (wraps at 8 bits), then REQ_LAYER.
- Counters:
  - beat: 16 bits.
  - neuron_idx: 8 bits.
  - act_rd_addr multiply is truncated to ADDR_W.
- Activation addressing: cant_inputs is latched but not used for addressing; iters_per_neuron governs the beat count.
- Signal overlap: get_weight and next_neuron are never high together, and next_layer is never high with either.

Decomposition:
- Package fc_seq_pkg holds:
  - the state enum;
  - a descriptor struct with the eight fields;
  - a function lane_mask(modulo, INPUTS_MAC).
- Optional sub-module fc_beat_ctrl: beat counter, address generation, and the one-cycle-delayed mac_en/clear/last/mask pipeline.

Test Plan:
- Single layer with cant_inputs=12, iters=2, modulo=0, neurons=2, last=1, of_offset=0x100, acc_valid 3 cycles after mac_last:
  - one next_layer;
  - get_weight pairs with act_rd_addr 0,6 per neuron;
  - mac_clear/mac_last on beats 0/1;
  - writes to 0x100 and 0x101;
  - two next_neuron pulses;
  - done once; busy low afterwards.
- iters=3, modulo=4: masks 0x3F, 0x3F, 0x0F; act_rd_addr 0, 6, 12.
- Two layers, last=0 then last=5:
  - next_layer pulses twice;
  - act_bank 0 then 1; layer_idx 0 then 1;
  - quant_n/quant_frac track each descriptor.
- cant_neurons=0, last=1: no get_weight and no out_wr_en; done 1 cycle after struct_ready processing.
- rst asserted in the 2nd FETCH cycle:
  - next cycle all outputs are 0 and the state is IDLE;
  - a new start repeats the full sequence from layer 0.
- acc_valid delayed 10 cycles, plus start pulsed while busy:
  - no next_neuron or get_weight during the wait;
  - the extra start has no effect;
  - exactly one NEXT_GAP idle cycle between neurons.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared types for the FC layer sequencer: FSM states, latched layer descriptor, lane-mask helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_LAYER,
    WAIT_DESC,
    FETCH,
    WAIT_ACC,
    NEXT_GAP,
    LAYER_END
  } state_t;

  typedef struct packed {
    logic [15:0] cant_inputs;
    logic [15:0] iters_per_neuron;
    logic [7:0]  modulo;
    logic [7:0]  cant_neurons;
    logic [7:0]  last;
    logic [15:0] of_offset;
    logic [7:0]  n;
    logic [7:0]  frac;
  } desc_t;

  localparam int MAX_LANES = 32;

  // Valid-lane mask for the final beat of a neuron. modulo==0 means every lane is
  // valid; modulo larger than the lane count saturates to the lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(input logic [7:0] modulo, input int lanes);
    int                   k;
    logic [MAX_LANES:0]   m;
    if (modulo == 8'd0 || int'(modulo) > lanes) k = lanes;
    else                                        k = int'(modulo);
    m = ((MAX_LANES+1)'(1) << k) - (MAX_LANES+1)'(1);
    return m[MAX_LANES-1:0];
  endfunction

endpackage

// File: rtl/fc_beat_ctrl.sv
// Beat counter, activation address generation and the registered MAC lane-control pipeline.
// Latency: act_rd_addr combinational in the fetch cycle; mac_* controls one cycle after the fetch.
// Backpressure: none; the parent FSM decides when fetch is asserted.
module fc_beat_ctrl
  import fc_seq_pkg::*;
#(
  parameter int INPUTS_MAC = 6,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch,
  input  logic                  clr,
  input  logic [15:0]           iters,
  input  logic [7:0]            modulo,
  output logic                  beat_last,
  output logic [ADDR_W-1:0]     act_rd_addr,
  output logic                  mac_en,
  output logic                  mac_clear,
  output logic                  mac_last,
  output logic [INPUTS_MAC-1:0] mac_lane_mask
);

  logic [15:0]          beat;
  logic                 beat_first;
  logic [MAX_LANES-1:0] lm_full;

  assign beat_first = (beat == 16'd0);
  assign beat_last  = (beat == iters - 16'd1);
  assign lm_full    = lane_mask(modulo, INPUTS_MAC);

  // Activation address is only driven while a weight beat is being requested.
  assign act_rd_addr = fetch ? (ADDR_W'(beat) * ADDR_W'(INPUTS_MAC)) : '0;

  // Beat counter: restarts at each new layer descriptor and each accepted neuron.
  always_ff @(posedge clk) begin
    if (rst)        beat <= 16'd0;
    else if (clr)   beat <= 16'd0;
    else if (fetch) beat <= beat + 16'd1;
  end

  // MAC controls line up with kernel/bias, which the provider returns one cycle after get_weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_en        <= 1'b0;
      mac_clear     <= 1'b0;
      mac_last      <= 1'b0;
      mac_lane_mask <= '0;
    end else begin
      mac_en    <= fetch;
      mac_clear <= fetch && beat_first;
      mac_last  <= fetch && beat_last;
      if (!fetch)         mac_lane_mask <= '0;
      else if (beat_last) mac_lane_mask <= lm_full[INPUTS_MAC-1:0];
      else                mac_lane_mask <= '1;
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// Network sequencer: requests layer descriptors, streams weight beats per neuron, writes MAC results out.
// Latency: next_layer 1 cycle after start; get_weight 1 cycle after struct_ready; write in the acc_valid cycle.
// Backpressure: stalls indefinitely in WAIT_DESC for struct_ready and in WAIT_ACC for acc_valid.
module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int INPUTS_MAC = 6,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  next_layer,
  output logic                  next_neuron,
  output logic                  get_weight,
  input  logic                  struct_ready,
  input  logic [15:0]           cant_inputs,
  input  logic [15:0]           iters_per_neuron,
  input  logic [7:0]            modulo,
  input  logic [7:0]            cant_neurons,
  input  logic [7:0]            last,
  input  logic [15:0]           of_offset,
  input  logic [7:0]            n,
  input  logic [7:0]            frac,
  output logic [ADDR_W-1:0]     act_rd_addr,
  output logic                  act_bank,
  output logic                  mac_en,
  output logic                  mac_clear,
  output logic                  mac_last,
  output logic [INPUTS_MAC-1:0] mac_lane_mask,
  input  logic                  acc_valid,
  output logic                  out_wr_en,
  output logic [ADDR_W-1:0]     out_wr_addr,
  output logic [7:0]            quant_n,
  output logic [7:0]            quant_frac,
  output logic [7:0]            layer_idx
);

  state_t      state, next_state;
  desc_t       desc;
  logic [7:0]  neuron_idx;
  logic        act_bank_r;
  logic [7:0]  layer_idx_r;
  logic        beat_last;
  logic        desc_take;
  logic        accept;
  logic        beat_clr;

  assign desc_take = (state == WAIT_DESC) && struct_ready;
  assign accept    = (state == WAIT_ACC) && acc_valid;
  assign beat_clr  = desc_take || accept;

  assign act_bank   = act_bank_r;
  assign layer_idx  = layer_idx_r;
  assign quant_n    = desc.n;
  assign quant_frac = desc.frac;

  fc_beat_ctrl #(
    .INPUTS_MAC (INPUTS_MAC),
    .ADDR_W     (ADDR_W)
  ) u_beat (
    .clk           (clk),
    .rst           (rst),
    .fetch         (get_weight),
    .clr           (beat_clr),
    .iters         (desc.iters_per_neuron),
    .modulo        (desc.modulo),
    .beat_last     (beat_last),
    .act_rd_addr   (act_rd_addr),
    .mac_en        (mac_en),
    .mac_clear     (mac_clear),
    .mac_last      (mac_last),
    .mac_lane_mask (mac_lane_mask)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and strobe decode; every strobe is a function of the current state
  // (plus acc_valid for the write), so a reset cycle silences all of them.
  always_comb begin
    next_state  = state;
    busy        = 1'b0;
    done        = 1'b0;
    next_layer  = 1'b0;
    next_neuron = 1'b0;
    get_weight  = 1'b0;
    out_wr_en   = 1'b0;
    out_wr_addr = '0;
    unique case (state)
      IDLE: begin
        if (start) next_state = REQ_LAYER;
      end
      REQ_LAYER: begin
        busy       = 1'b1;
        next_layer = 1'b1;
        next_state = WAIT_DESC;
      end
      WAIT_DESC: begin
        busy = 1'b1;
        if (struct_ready) begin
          if (cant_neurons == 8'd0 || iters_per_neuron == 16'd0) next_state = LAYER_END;
          else                                                    next_state = FETCH;
        end
      end
      FETCH: begin
        busy       = 1'b1;
        get_weight = 1'b1;
        if (beat_last) next_state = WAIT_ACC;
      end
      WAIT_ACC: begin
        busy = 1'b1;
        if (acc_valid) begin
          out_wr_en   = 1'b1;
          next_neuron = 1'b1;
          out_wr_addr = ADDR_W'(desc.of_offset) + ADDR_W'(neuron_idx);
          next_state  = NEXT_GAP;
        end
      end
      NEXT_GAP: begin
        busy = 1'b1;
        if (neuron_idx == desc.cant_neurons) next_state = LAYER_END;
        else                                 next_state = FETCH;
      end
      LAYER_END: begin
        if (desc.last != 8'd0) begin
          done       = 1'b1;
          next_state = IDLE;
        end else begin
          busy       = 1'b1;
          next_state = REQ_LAYER;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Descriptor latch, neuron index, layer index and ping-pong bank tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc        <= '0;
      neuron_idx  <= 8'd0;
      act_bank_r  <= 1'b0;
      layer_idx_r <= 8'd0;
    end else begin
      if (state == IDLE && start) begin
        layer_idx_r <= 8'd0;
        act_bank_r  <= 1'b0;
      end
      if (desc_take) begin
        desc.cant_inputs      <= cant_inputs;
        desc.iters_per_neuron <= iters_per_neuron;
        desc.modulo           <= modulo;
        desc.cant_neurons     <= cant_neurons;
        desc.last             <= last;
        desc.of_offset        <= of_offset;
        desc.n                <= n;
        desc.frac             <= frac;
        neuron_idx            <= 8'd0;
      end
      if (accept) neuron_idx <= neuron_idx + 8'd1;
      if (state == LAYER_END && desc.last == 8'd0) begin
        act_bank_r  <= ~act_bank_r;
        layer_idx_r <= layer_idx_r + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: provider/MAC responses driven inline, outputs logged at negedge.
// Latency: n/a.
// Backpressure: n/a.
module tb_fc_layer_sequencer;
  import fc_seq_pkg::*;

  localparam int IM = 6;
  localparam int AW = 16;

  logic          clk, rst, start, struct_ready, acc_valid;
  logic [15:0]   cant_inputs, iters_per_neuron, of_offset;
  logic [7:0]    modulo, cant_neurons, last, n, frac;
  logic          busy, done, next_layer, next_neuron, get_weight;
  logic [AW-1:0] act_rd_addr, out_wr_addr;
  logic          act_bank, mac_en, mac_clear, mac_last, out_wr_en;
  logic [IM-1:0] mac_lane_mask;
  logic [7:0]    quant_n, quant_frac, layer_idx;

  fc_layer_sequencer #(.INPUTS_MAC(IM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .next_layer(next_layer), .next_neuron(next_neuron), .get_weight(get_weight),
    .struct_ready(struct_ready), .cant_inputs(cant_inputs), .iters_per_neuron(iters_per_neuron),
    .modulo(modulo), .cant_neurons(cant_neurons), .last(last), .of_offset(of_offset),
    .n(n), .frac(frac), .act_rd_addr(act_rd_addr), .act_bank(act_bank), .mac_en(mac_en),
    .mac_clear(mac_clear), .mac_last(mac_last), .mac_lane_mask(mac_lane_mask),
    .acc_valid(acc_valid), .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr),
    .quant_n(quant_n), .quant_frac(quant_frac), .layer_idx(layer_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event logs, written only by the monitor.
  int            cyc = 0, nl_n = 0, gw_n = 0, nn_n = 0, wr_n = 0, mac_n = 0, done_n = 0, ovl_n = 0;
  logic [AW-1:0] gw_addr [256];
  int            gw_cyc  [256];
  logic [IM-1:0] mask_log[256];
  logic          clr_log [256];
  logic          last_log[256];
  logic [AW-1:0] wr_addr [64];
  int            wr_cyc  [64];
  logic          wr_bank [64];
  logic [7:0]    wr_layer[64];
  logic [7:0]    wr_qn   [64];
  logic [7:0]    wr_qf   [64];

  // Snapshots taken by the stimulus at the start of each scenario.
  int b_nl, b_gw, b_nn, b_wr, b_mac, b_done;

  always @(negedge clk) begin
    cyc++;
    if (next_layer) nl_n++;
    if (next_neuron) nn_n++;
    if (done) done_n++;
    if ((get_weight && next_neuron) || (next_layer && (get_weight || next_neuron))) ovl_n++;
    if (get_weight) begin
      if (gw_n < 256) begin
        gw_addr[gw_n] = act_rd_addr;
        gw_cyc[gw_n]  = cyc;
      end
      gw_n++;
    end
    if (mac_en) begin
      if (mac_n < 256) begin
        mask_log[mac_n] = mac_lane_mask;
        clr_log[mac_n]  = mac_clear;
        last_log[mac_n] = mac_last;
      end
      mac_n++;
    end
    if (out_wr_en) begin
      if (wr_n < 64) begin
        wr_addr[wr_n]  = out_wr_addr;
        wr_cyc[wr_n]   = cyc;
        wr_bank[wr_n]  = act_bank;
        wr_layer[wr_n] = layer_idx;
        wr_qn[wr_n]    = quant_n;
        wr_qf[wr_n]    = quant_frac;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{busy, done, next_layer, next_neuron, get_weight, act_rd_addr, act_bank, mac_en,
             mac_clear, mac_last, mac_lane_mask, out_wr_en, out_wr_addr, quant_n, quant_frac,
             layer_idx};
  endfunction

  function automatic logic sig_sel(input int sel);
    case (sel)
      0:       return next_layer;
      1:       return mac_last;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel);
    int k = 0;
    while (!sig_sel(sel) && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 32'(sig_sel(sel)), 1);
  endtask

  task automatic snap();
    b_nl = nl_n; b_gw = gw_n; b_nn = nn_n; b_wr = wr_n; b_mac = mac_n; b_done = done_n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Provider model: answers next_layer with a one-cycle struct_ready, then scrambles the fields.
  task automatic give_desc(input logic [15:0] cin, input logic [15:0] it, input logic [7:0] md,
                           input logic [7:0] neu, input logic [7:0] lst, input logic [15:0] off,
                           input logic [7:0] qn, input logic [7:0] qf);
    wait_for("wait_next_layer", 0);
    tick();
    struct_ready = 1'b1;
    cant_inputs = cin; iters_per_neuron = it; modulo = md; cant_neurons = neu;
    last = lst; of_offset = off; n = qn; frac = qf;
    tick();
    struct_ready = 1'b0;
    cant_inputs = 16'hDEAD; iters_per_neuron = 16'h0BAD; modulo = 8'h03; cant_neurons = 8'h77;
    last = 8'h00; of_offset = 16'hBEEF; n = 8'hEE; frac = 8'hDD;
  endtask

  // MAC model: result valid d cycles after mac_last (d=0 coincides with mac_last).
  task automatic finish_neuron(input int d);
    wait_for("wait_mac_last", 1);
    repeat (d) tick();
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, n0;
    rst = 1'b1; start = 1'b0; struct_ready = 1'b0; acc_valid = 1'b0;
    cant_inputs = '0; iters_per_neuron = '0; modulo = '0; cant_neurons = '0;
    last = '0; of_offset = '0; n = '0; frac = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("reset_outputs", 32'(any_out()), 0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));

    // 1: single layer, 2 neurons x 2 beats, acc 3 cycles after mac_last
    snap();
    pulse_start();
    chk("s1_busy_after_start", 32'(busy), 1);
    give_desc(16'd12, 16'd2, 8'd0, 8'd2, 8'd1, 16'h0100, 8'd3, 8'd5);
    finish_neuron(3);
    finish_neuron(3);
    wait_for("s1_wait_done", 2);
    chk("s1_busy_at_done", 32'(busy), 0);
    tick();
    chk("s1_busy_after", 32'(busy), 0);
    chk("s1_done_pulse", 32'(done), 0);
    chk("s1_next_layer_cnt", 32'(nl_n - b_nl), 1);
    chk("s1_get_weight_cnt", 32'(gw_n - b_gw), 4);
    chk("s1_mac_en_cnt", 32'(mac_n - b_mac), 4);
    for (int i = 0; i < 4; i++) begin
      chk("s1_act_rd_addr", 32'(gw_addr[b_gw+i]), (i % 2) * 6);
      chk("s1_mac_clear", 32'(clr_log[b_mac+i]), (i % 2 == 0) ? 1 : 0);
      chk("s1_mac_last", 32'(last_log[b_mac+i]), (i % 2 == 1) ? 1 : 0);
      chk("s1_mask", 32'(mask_log[b_mac+i]), 'h3F);
    end
    chk("s1_wr_cnt", 32'(wr_n - b_wr), 2);
    chk("s1_wr_addr0", 32'(wr_addr[b_wr]), 'h100);
    chk("s1_wr_addr1", 32'(wr_addr[b_wr+1]), 'h101);
    chk("s1_next_neuron_cnt", 32'(nn_n - b_nn), 2);
    chk("s1_done_cnt", 32'(done_n - b_done), 1);

    // 2: partial final beat, modulo=4; acc_valid together with mac_last
    snap();
    pulse_start();
    give_desc(16'd16, 16'd3, 8'd4, 8'd1, 8'd1, 16'h0020, 8'd0, 8'd0);
    finish_neuron(0);
    wait_for("s2_wait_done", 2);
    tick();
    chk("s2_get_weight_cnt", 32'(gw_n - b_gw), 3);
    for (int i = 0; i < 3; i++) begin
      chk("s2_act_rd_addr", 32'(gw_addr[b_gw+i]), i * 6);
      chk("s2_mask", 32'(mask_log[b_mac+i]), (i == 2) ? 'h0F : 'h3F);
      chk("s2_mac_last", 32'(last_log[b_mac+i]), (i == 2) ? 1 : 0);
    end
    chk("s2_wr_cnt", 32'(wr_n - b_wr), 1);
    chk("s2_wr_addr", 32'(wr_addr[b_wr]), 'h20);

    // 3: two layers, last=0 then last=5
    snap();
    pulse_start();
    give_desc(16'd6, 16'd1, 8'd0, 8'd1, 8'd0, 16'h0010, 8'd1, 8'd2);
    finish_neuron(1);
    give_desc(16'd6, 16'd1, 8'd0, 8'd1, 8'd5, 16'h0040, 8'd7, 8'd9);
    finish_neuron(1);
    wait_for("s3_wait_done", 2);
    tick();
    chk("s3_next_layer_cnt", 32'(nl_n - b_nl), 2);
    chk("s3_done_cnt", 32'(done_n - b_done), 1);
    chk("s3_wr_cnt", 32'(wr_n - b_wr), 2);
    for (int i = 0; i < 2; i++) begin
      chk("s3_bank", 32'(wr_bank[b_wr+i]), i);
      chk("s3_layer_idx", 32'(wr_layer[b_wr+i]), i);
      chk("s3_quant_n", 32'(wr_qn[b_wr+i]), (i == 0) ? 1 : 7);
      chk("s3_quant_frac", 32'(wr_qf[b_wr+i]), (i == 0) ? 2 : 9);
      chk("s3_wr_addr", 32'(wr_addr[b_wr+i]), (i == 0) ? 'h10 : 'h40);
      chk("s3_clear_and_last", 32'({clr_log[b_mac+i], last_log[b_mac+i]}), 3);
    end
    chk("s3_bank_held", 32'(act_bank), 1);
    chk("s3_layer_held", 32'(layer_idx), 1);

    // 4: empty layer
    snap();
    pulse_start();
    give_desc(16'd0, 16'd4, 8'd0, 8'd0, 8'd1, 16'h0000, 8'd0, 8'd0);
    chk("s4_done", 32'(done), 1);
    chk("s4_busy_at_done", 32'(busy), 0);
    chk("s4_bank_restart", 32'(act_bank), 0);
    tick();
    chk("s4_done_one_cycle", 32'(done), 0);
    chk("s4_get_weight_cnt", 32'(gw_n - b_gw), 0);
    chk("s4_wr_cnt", 32'(wr_n - b_wr), 0);

    // 5: reset in the second FETCH cycle, then a clean rerun
    snap();
    pulse_start();
    give_desc(16'd18, 16'd3, 8'd0, 8'd1, 8'd1, 16'h0080, 8'd2, 8'd2);
    chk("s5_fetch1_gw", 32'(get_weight), 1);
    tick();
    chk("s5_fetch2_addr", 32'(act_rd_addr), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_outputs", 32'(any_out()), 0);
    chk("s5_rst_state", 32'(dut.state), 32'(IDLE));
    repeat (3) tick();
    chk("s5_idle_no_req", 32'(nl_n - b_nl), 1);
    chk("s5_idle_no_busy", 32'(busy), 0);
    snap();
    pulse_start();
    give_desc(16'd12, 16'd2, 8'd0, 8'd1, 8'd1, 16'h0055, 8'd4, 8'd4);
    finish_neuron(2);
    wait_for("s5_wait_done", 2);
    tick();
    chk("s5_rerun_next_layer", 32'(nl_n - b_nl), 1);
    chk("s5_rerun_gw_cnt", 32'(gw_n - b_gw), 2);
    chk("s5_rerun_wr_addr", 32'(wr_addr[b_wr]), 'h55);
    chk("s5_rerun_layer", 32'(wr_layer[b_wr]), 0);
    chk("s5_rerun_done", 32'(done_n - b_done), 1);

    // 6: long acc wait with a start pulse while busy
    snap();
    pulse_start();
    give_desc(16'd12, 16'd2, 8'd0, 8'd2, 8'd1, 16'h0200, 8'd0, 8'd0);
    wait_for("s6_wait_mac_last", 1);
    g0 = gw_n;
    n0 = nn_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("s6_no_gw_in_wait", 32'(gw_n - g0), 0);
    chk("s6_no_nn_in_wait", 32'(nn_n - n0), 0);
    chk("s6_busy_in_wait", 32'(busy), 1);
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    finish_neuron(2);
    wait_for("s6_wait_done", 2);
    tick();
    chk("s6_gap_cycles", 32'(gw_cyc[b_gw+2] - wr_cyc[b_wr]), 2);
    chk("s6_next_layer_cnt", 32'(nl_n - b_nl), 1);
    chk("s6_wr_addr0", 32'(wr_addr[b_wr]), 'h200);
    chk("s6_wr_addr1", 32'(wr_addr[b_wr+1]), 'h201);
    chk("s6_done_cnt", 32'(done_n - b_done), 1);

    chk("strobe_overlap", 32'(ovl_n), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
